hall_quad_counter: RTL and testbench
====================================

# hall_quad_counter

Parametrised hall-sensor position and speed decoder for the BLDC drive. It takes the three raw hall lines from a motor, synchronises and glitch-filters them, and decodes the 6-step sequence into a signed position count and direction. It also reports the period between valid steps and flags invalid codes. It sits between the hall input pins and the motor-control/odometry logic, replacing the fixed 8-bit hall counter.

## Interface
Parameters:
- COUNT_W, 16, width of signed position count (≥ 4)
- FILT_CYCLES, 4, consecutive stable cycles required to accept a new hall code (1..255)
- PERIOD_W, 20, width of step-period counter (≥ 4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- hall  in  3  raw hall sensor lines, asynchronous to clk
- clr  in  1  synchronous clear of count
- count  out  COUNT_W  signed position, two's complement
- dir  out  1  direction of last valid step (1 = forward)
- step_pulse  out  1  one-cycle pulse on each valid step
- hall_err  out  1  one-cycle pulse on invalid code or skipped sector
- period  out  PERIOD_W  clk cycles between the last two valid steps
- period_valid  out  1  one-cycle pulse when period updates
- stalled  out  1  high while the step timer is saturated

## Operation
- Sync: 2-FF synchroniser on hall gives hall_s.
- Filter:
  - Stability counter restarts whenever hall_s changes.
  - hall_f takes hall_s once hall_s ≠ hall_f has held for FILT_CYCLES consecutive cycles.
  - Shorter glitches are discarded.
- Sector map for hall_f = {A,B,C}: 001→0, 011→1, 010→2, 110→3, 100→4, 101→5. Codes 000 and 111 are invalid.
- Decode runs on each hall_f update, using the stored sector and a ref_valid flag:
  - Invalid code: hall_err pulse; ref_valid cleared; count unchanged.
  - Valid code with ref_valid = 0: store the sector and set ref_valid. No step, no error. This covers the first code after reset or after an error.
  - Sector = prev+1 mod 6: count +1, dir = 1, step_pulse.
  - Sector = prev−1 mod 6: count −1, dir = 0, step_pulse.
  - Difference of 2 or 3 (skipped sector): hall_err pulse; the sector is re-referenced to the new value; count and dir unchanged.
- count arithmetic:
  - Wraps modulo 2^COUNT_W; +1 from max positive gives min negative, and vice versa. No saturation.
  - clr forces count to 0 and has priority over a coincident step. dir, step_pulse and the period logic still act on that step.
- Step timer:
  - Increments every cycle and saturates at all-ones; stalled = 1 while saturated.
  - On a valid step: period ← timer value (all-ones if saturated), period_valid pulse, timer ← 1, stalled ← 0.
  - Error and re-reference events do not touch the timer.
  - The first step after reset reports the cycles since reset.

## Timing
- Reset values:
  - Outputs: count 0, dir 0, step_pulse 0, hall_err 0, period 0, period_valid 0, stalled 0.
  - Internal: timer 0, ref_valid 0; sync and filter registers 000, with hall_f treated as invalid.
- Latency: a hall change sampled at edge E, held stable, updates hall_f at edge E+1+FILT_CYCLES. count, dir, step_pulse, hall_err, period and period_valid update at edge E+2+FILT_CYCLES.
- step_pulse, hall_err and period_valid are single-cycle. step_pulse and hall_err are never high together.
- Reset mid-filter or mid-step discards pending state. Decoding resumes without counting on the first accepted valid code.

## Test plan
- Forward sequence 001,011,010,110,100,101,001 with each code held 20 cycles (FILT_CYCLES=4) → first code only references; 6 step_pulses; count = 6; dir = 1; each step appears 6 cycles after the hall edge; period = 20 from the second step on.
- Reverse sequence from count 6 → count decrements to 0; dir = 0; no hall_err.
- Glitch test: 3-cycle pulse 011→010→011 → no hall_f change, no step. 000 held 10 cycles → hall_err once, ref_valid cleared, next valid code produces no step.
- Skip test: 001→010 → hall_err, count unchanged; following 110 → count +1.
- Wrap and clear with COUNT_W=4: count 7 then a forward step → −8. clr asserted in the same cycle as a step → count 0, step_pulse 1.
- Stall test with PERIOD_W=4: no edges for 30 cycles → stalled = 1; next step gives period = 15, stalled = 0.

Source files
------------

// File: rtl/hall_quad_counter.sv
// Hall-sensor 6-step decoder: synchronises and filters the three hall lines,
// then tracks signed position, direction, step period and invalid/skip errors.
module hall_quad_counter #(
  parameter int COUNT_W     = 16,
  parameter int FILT_CYCLES = 4,
  parameter int PERIOD_W    = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 hall,
  input  logic                       clr,
  output logic signed [COUNT_W-1:0]  count,
  output logic                       dir,
  output logic                       step_pulse,
  output logic                       hall_err,
  output logic [PERIOD_W-1:0]        period,
  output logic                       period_valid,
  output logic                       stalled
);

  localparam logic [COUNT_W-1:0]  COUNT_ONE = 1;
  localparam logic [PERIOD_W-1:0] TIMER_ONE = 1;
  localparam logic [PERIOD_W-1:0] TIMER_MAX = '1;
  localparam logic [8:0]          FILT_LEN  = 9'(FILT_CYCLES);

  logic [2:0]          sync1;
  logic [2:0]          hall_s;
  logic [2:0]          hall_f;
  logic [7:0]          stab_cnt;
  logic                f_upd;
  logic [2:0]          ref_sector;
  logic                ref_valid;
  logic [PERIOD_W-1:0] timer;

  // Returns {valid, sector}; 000 and 111 map to invalid.
  function automatic logic [3:0] decode_sector(input logic [2:0] code);
    case (code)
      3'b001:  return 4'b1000;
      3'b011:  return 4'b1001;
      3'b010:  return 4'b1010;
      3'b110:  return 4'b1011;
      3'b100:  return 4'b1100;
      3'b101:  return 4'b1101;
      default: return 4'b0000;
    endcase
  endfunction

  // stab_cnt + 1 is the number of cycles hall_s has shown its current value.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 3'b000;
      hall_s   <= 3'b000;
      hall_f   <= 3'b000;
      stab_cnt <= 8'd0;
      f_upd    <= 1'b0;
    end else begin
      sync1  <= hall;
      hall_s <= sync1;
      f_upd  <= 1'b0;
      if (sync1 != hall_s)
        stab_cnt <= 8'd0;
      else if (stab_cnt != 8'hFF)
        stab_cnt <= stab_cnt + 8'd1;
      if (hall_s != hall_f && ({1'b0, stab_cnt} + 9'd1) >= FILT_LEN) begin
        hall_f <= hall_s;
        f_upd  <= 1'b1;
      end
    end
  end

  logic [3:0] dec;
  logic [3:0] diff_raw;
  logic [3:0] diff;
  logic       code_ok;
  logic       fwd;
  logic       rev;
  logic       skip;
  logic       inv;

  always_comb begin
    dec      = decode_sector(hall_f);
    code_ok  = dec[3];
    diff_raw = {1'b0, dec[2:0]} + 4'd6 - {1'b0, ref_sector};
    diff     = (diff_raw >= 4'd6) ? diff_raw - 4'd6 : diff_raw;
    fwd      = f_upd && code_ok && ref_valid && (diff == 4'd1);
    rev      = f_upd && code_ok && ref_valid && (diff == 4'd5);
    skip     = f_upd && code_ok && ref_valid && (diff >= 4'd2) && (diff <= 4'd4);
    inv      = f_upd && !code_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sector <= 3'd0;
      ref_valid  <= 1'b0;
      count      <= '0;
      dir        <= 1'b0;
      step_pulse <= 1'b0;
      hall_err   <= 1'b0;
    end else begin
      step_pulse <= fwd || rev;
      hall_err   <= inv || skip;
      if (inv) begin
        ref_valid <= 1'b0;
      end else if (f_upd) begin
        // Reference, step and skip all re-anchor on the new sector.
        ref_sector <= dec[2:0];
        ref_valid  <= 1'b1;
      end
      if (fwd)
        dir <= 1'b1;
      else if (rev)
        dir <= 1'b0;
      if (clr)
        count <= '0;
      else if (fwd)
        count <= count + COUNT_ONE;
      else if (rev)
        count <= count - COUNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
    end else if (fwd || rev) begin
      period       <= timer;
      period_valid <= 1'b1;
      timer        <= TIMER_ONE;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (timer != TIMER_MAX)
        timer <= timer + TIMER_ONE;
      stalled <= (timer >= TIMER_MAX - TIMER_ONE);
    end
  end

endmodule

// File: tb/tb_hall_quad_counter.sv
// Bench for hall_quad_counter: two instances (wide and narrow) share stimulus
// and are checked every cycle against a sequence-level behavioural model.
module tb_hall_quad_counter;

  localparam int FILT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  hall = 3'b000;
  logic        clr = 1'b0;

  logic signed [15:0] b_count;
  logic               b_dir, b_step, b_err, b_pv, b_stalled;
  logic [19:0]        b_period;
  logic signed [3:0]  s_count;
  logic               s_dir, s_step, s_err, s_pv, s_stalled;
  logic [3:0]         s_period;

  hall_quad_counter #(.COUNT_W(16), .FILT_CYCLES(FILT), .PERIOD_W(20)) u_big (
    .clk(clk), .rst(rst), .hall(hall), .clr(clr),
    .count(b_count), .dir(b_dir), .step_pulse(b_step), .hall_err(b_err),
    .period(b_period), .period_valid(b_pv), .stalled(b_stalled)
  );

  hall_quad_counter #(.COUNT_W(4), .FILT_CYCLES(FILT), .PERIOD_W(4)) u_small (
    .clk(clk), .rst(rst), .hall(hall), .clr(clr),
    .count(s_count), .dir(s_dir), .step_pulse(s_step), .hall_err(s_err),
    .period(s_period), .period_valid(s_pv), .stalled(s_stalled)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  // ---------------- behavioural model ----------------
  int m_s1, m_s2, m_age, m_hf, m_fupd, m_ref, m_refv;
  int m_count, m_dir, m_step, m_err, m_timer, m_period, m_pv;
  int seq_codes [6] = '{1, 3, 2, 6, 4, 5};

  function automatic int sector_of(input int code);
    for (int i = 0; i < 6; i++)
      if (seq_codes[i] == code) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_age = 0; m_hf = 0; m_fupd = 0; m_ref = 0; m_refv = 0;
    m_count = 0; m_dir = 0; m_step = 0; m_err = 0; m_timer = 0; m_period = 0; m_pv = 0;
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      int s, d;
      m_step = 0; m_err = 0; m_pv = 0;
      if (m_fupd != 0) begin
        s = sector_of(m_hf);
        if (s < 0) begin
          m_err = 1; m_refv = 0;
        end else if (m_refv == 0) begin
          m_ref = s; m_refv = 1;
        end else begin
          d = (s - m_ref + 6) % 6;
          if (d == 1) begin m_step = 1; m_count++; m_dir = 1; end
          else if (d == 5) begin m_step = 1; m_count--; m_dir = 0; end
          else m_err = 1;
          m_ref = s;
        end
      end
      if (clr) m_count = 0;
      if (m_step != 0) begin
        m_period = m_timer; m_pv = 1; m_timer = 1;
      end else if (m_timer < 1000000) begin
        m_timer++;
      end
      m_fupd = 0;
      if (m_s2 != m_hf && m_age >= FILT) begin
        m_hf = m_s2; m_fupd = 1;
      end
      if (m_s1 != m_s2) m_age = 1;
      else if (m_age < 1000) m_age++;
      m_s2 = m_s1;
      m_s1 = int'(hall);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] cv;
    logic [19:0] bp;
    logic [3:0]  sp;
    cv = m_count;
    bp = (m_period > 20'hFFFFF) ? 20'hFFFFF : 20'(m_period);
    sp = (m_period > 15) ? 4'hF : 4'(m_period);
    checks++;
    if (b_count !== cv[15:0] || b_dir !== m_dir[0] || b_step !== m_step[0] ||
        b_err !== m_err[0] || b_pv !== m_pv[0] || b_period !== bp ||
        b_stalled !== (m_timer >= 20'hFFFFF)) begin
      failures++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL cycle_big t=%0t got cnt=%0d dir=%b stp=%b err=%b per=%0d pv=%b stl=%b want cnt=%0d dir=%0d stp=%0d err=%0d per=%0d pv=%0d",
                 $time, b_count, b_dir, b_step, b_err, b_period, b_pv, b_stalled,
                 $signed(cv[15:0]), m_dir, m_step, m_err, bp, m_pv);
      end
    end
    checks++;
    if (s_count !== cv[3:0] || s_dir !== m_dir[0] || s_step !== m_step[0] ||
        s_err !== m_err[0] || s_pv !== m_pv[0] || s_period !== sp ||
        s_stalled !== (m_timer >= 15)) begin
      failures++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL cycle_small t=%0t got cnt=%0d dir=%b stp=%b err=%b per=%0d pv=%b stl=%b want cnt=%0d dir=%0d stp=%0d err=%0d per=%0d pv=%0d stl=%0d",
                 $time, s_count, s_dir, s_step, s_err, s_period, s_pv, s_stalled,
                 $signed(cv[3:0]), m_dir, m_step, m_err, sp, m_pv, (m_timer >= 15));
      end
    end
  end

  int err_seen = 0;
  int step_seen = 0;
  always @(negedge clk) begin
    if (b_err) err_seen++;
    if (b_step) step_seen++;
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, actual, expected);
    end
  endtask

  int txn = 0;
  task automatic hold(input logic [2:0] code, input int n);
    hall = code;
    repeat (n) @(negedge clk);
    txn++;
    $display("txn %0d hall=%b hold=%0d count=%0d dir=%b", txn, code, n, b_count, b_dir);
  endtask

  initial begin
    int lat, e0, s0, cur, r, n;
    logic [2:0] code;
    logic [2:0] fwd_seq [7] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    logic [2:0] rev_seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [2:0] wrap_seq [7] = '{3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};

    repeat (3) @(negedge clk);
    chk("rst_count", 32'(b_count), 0);
    chk("rst_period", 32'(b_period), 0);
    chk("rst_stalled", 32'(b_stalled), 0);
    rst = 1'b0;

    // Forward sequence; measure step latency on the second code.
    hold(fwd_seq[0], 20);
    hall = fwd_seq[1];
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (lat == 0 && b_step) lat = i;
    end
    // Hall driven half a cycle before edge E; step registered at E+6, seen 7 negedges later.
    chk("step_latency", 32'(lat), 7);
    for (int i = 2; i < 7; i++) hold(fwd_seq[i], 20);
    chk("fwd_count", 32'(b_count), 6);
    chk("fwd_count_small", 32'(s_count), 6);
    chk("fwd_dir", 32'(b_dir), 1);
    chk("fwd_period", 32'(b_period), 20);
    chk("fwd_period_small", 32'(s_period), 15);

    e0 = err_seen;
    for (int i = 0; i < 6; i++) hold(rev_seq[i], 20);
    chk("rev_count", 32'(b_count), 0);
    chk("rev_dir", 32'(b_dir), 0);
    chk("rev_no_err", 32'(err_seen - e0), 0);

    // Glitch then invalid code.
    hold(3'b011, 20);
    e0 = err_seen; s0 = step_seen;
    hold(3'b010, 3);
    hold(3'b011, 20);
    chk("glitch_no_step", 32'(step_seen - s0), 0);
    hold(3'b000, 10);
    hold(3'b011, 20);
    chk("invalid_err_once", 32'(err_seen - e0), 1);
    chk("invalid_no_step", 32'(step_seen - s0), 0);
    chk("invalid_count", 32'(b_count), 1);

    // Skip: 001 then 010 skips sector 1.
    hold(3'b001, 20);
    e0 = err_seen;
    hold(3'b010, 20);
    chk("skip_err", 32'(err_seen - e0), 1);
    chk("skip_count", 32'(b_count), 0);
    hold(3'b110, 20);
    chk("skip_then_step", 32'(b_count), 1);

    // Wrap on the 4-bit instance.
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 7; i++) hold(wrap_seq[i], 20);
    chk("wrap_pre", 32'(s_count), 7);
    hold(3'b101, 20);
    chk("wrap_small", {28'd0, s_count}, 32'h8);
    chk("wrap_big", 32'(b_count), 8);

    // Clear coincident with a step.
    hall = 3'b001;
    repeat (6) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_step_pulse", 32'(b_step), 1);
    chk("clr_count", 32'(b_count), 0);
    repeat (30) @(negedge clk);
    chk("stall_small", 32'(s_stalled), 1);

    hall = 3'b011;
    repeat (7) @(negedge clk);
    chk("stall_period", 32'(s_period), 15);
    chk("stall_pv", 32'(s_pv), 1);
    chk("stall_clear", 32'(s_stalled), 0);
    repeat (13) @(negedge clk);

    // Randomised phase.
    cur = 1;
    for (int t = 0; t < 250; t++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        cur = (cur + (($urandom_range(0, 1) == 0) ? 1 : 5)) % 6;
        code = 3'(seq_codes[cur]);
      end else if (r < 75) begin
        code = 3'($urandom_range(0, 7));
        if (sector_of(int'(code)) >= 0) cur = sector_of(int'(code));
      end else if (r < 85) begin
        code = 3'($urandom_range(0, 7));
        hold(code, int'($urandom_range(1, 3)));
        code = 3'(seq_codes[cur]);
      end else begin
        code = 3'(seq_codes[cur]);
      end
      n = int'($urandom_range(1, 14));
      if ($urandom_range(0, 24) == 0) clr = 1'b1;
      if ($urandom_range(0, 79) == 0) rst = 1'b1;
      hall = code;
      @(negedge clk);
      clr = 1'b0;
      rst = 1'b0;
      hold(code, n);
    end
    hold(3'(seq_codes[cur]), 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
